// File: rtl/if_id_pipe_stage_if.sv
// IF/ID stage bus: fetch-side beat with its handshake, hazard and flush controls,
// and the decode-side beat. The stage sees the slave view and the environment
// (fetch unit, hazard unit, decode) sees the master view.
interface if_id_pipe_stage_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            hit;
    logic            in_ready;
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_four;
    logic            stall;
    logic            flush;
    logic            out_valid;
    logic [ILEN-1:0] out_instruction;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_next_pc;

    modport master (
        output in_valid, hit, instruction, pc, pc_plus_four, stall, flush,
        input  in_ready, out_valid, out_instruction, out_pc, out_next_pc
    );

    modport slave (
        input  in_valid, hit, instruction, pc, pc_plus_four, stall, flush,
        output in_ready, out_valid, out_instruction, out_pc, out_next_pc
    );
endinterface

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: one output register plus an optional 1-entry skid
// buffer, so the fetch side sees a ready that depends only on stage state.
// Flush kills everything held and the incoming beat; stall and flush
// activity is tracked in saturating counters.
module if_id_pipe_stage #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INSN = ILEN'(32'h00000013),
    parameter bit              SKID_EN  = 1'b1,
    parameter int              CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    if_id_pipe_stage_if.slave  pipe_if,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    logic            main_valid_q, main_valid_d;
    logic [ILEN-1:0] main_insn_q,  main_insn_d;
    logic [XLEN-1:0] main_pc_q,    main_pc_d;
    logic [XLEN-1:0] main_npc_q,   main_npc_d;

    logic            skid_valid_q, skid_valid_d;
    logic [ILEN-1:0] skid_insn_q,  skid_insn_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    logic [XLEN-1:0] skid_npc_q,   skid_npc_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic main_free;
    logic in_ready;
    logic in_fire;

    // Main register can take a new beat when it is empty or its beat leaves now.
    assign main_free = ~main_valid_q | ~pipe_if.stall;
    assign in_fire   = pipe_if.in_valid & pipe_if.hit & in_ready;

    // Ready: with a skid, depends only on skid occupancy; without, on main state and stall.
    always_comb begin
        if (SKID_EN) begin
            in_ready = rst_n_i & ~skid_valid_q;
        end else begin
            in_ready = rst_n_i & main_free;
        end
    end

    // Next-state for main and skid entries; flush overrides every other update.
    always_comb begin
        main_valid_d = main_valid_q;
        main_insn_d  = main_insn_q;
        main_pc_d    = main_pc_q;
        main_npc_d   = main_npc_q;
        skid_valid_d = skid_valid_q;
        skid_insn_d  = skid_insn_q;
        skid_pc_d    = skid_pc_q;
        skid_npc_d   = skid_npc_q;
        if (pipe_if.flush) begin
            // PC fields hold so debug still sees the last killed instruction's address.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_insn_d  = skid_insn_q;
                main_pc_d    = skid_pc_q;
                main_npc_d   = skid_npc_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_insn_d  = pipe_if.instruction;
                main_pc_d    = pipe_if.pc;
                main_npc_d   = pipe_if.pc_plus_four;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire && SKID_EN) begin
            skid_valid_d = 1'b1;
            skid_insn_d  = pipe_if.instruction;
            skid_pc_d    = pipe_if.pc;
            skid_npc_d   = pipe_if.pc_plus_four;
        end
    end

    // Saturating perf counters; a flush cycle is not counted as a stall cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && pipe_if.stall && !pipe_if.flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (pipe_if.flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            main_insn_q  <= NOP_INSN;
            main_pc_q    <= '0;
            main_npc_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_insn_q  <= NOP_INSN;
            skid_pc_q    <= '0;
            skid_npc_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_insn_q  <= main_insn_d;
            main_pc_q    <= main_pc_d;
            main_npc_q   <= main_npc_d;
            skid_valid_q <= skid_valid_d;
            skid_insn_q  <= skid_insn_d;
            skid_pc_q    <= skid_pc_d;
            skid_npc_q   <= skid_npc_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Empty slot always presents a NOP so decode never sees stale bits.
    assign pipe_if.out_instruction = main_valid_q ? main_insn_q : NOP_INSN;
    assign pipe_if.out_valid       = main_valid_q;
    assign pipe_if.out_pc          = main_pc_q;
    assign pipe_if.out_next_pc     = main_npc_q;
    assign pipe_if.in_ready        = in_ready;
    assign stall_cnt_o             = stall_cnt_q;
    assign flush_cnt_o             = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: directed stimulus with a scoreboard queue for the
// default configuration, plus direct checks on SKID_EN=0 and CNT_W=4 instances.
module tb_if_id_pipe_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_id_pipe_stage_if #(.XLEN(32), .ILEN(32)) bm ();
    if_id_pipe_stage_if #(.XLEN(32), .ILEN(32)) bn ();
    if_id_pipe_stage_if #(.XLEN(32), .ILEN(32)) bs ();

    logic [15:0] m_stall_cnt, m_flush_cnt, n_stall_cnt, n_flush_cnt;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    if_id_pipe_stage u_main (
        .clk_i(clk), .rst_n_i(rst_n), .pipe_if(bm),
        .stall_cnt_o(m_stall_cnt), .flush_cnt_o(m_flush_cnt)
    );
    if_id_pipe_stage #(.SKID_EN(1'b0)) u_nsk (
        .clk_i(clk), .rst_n_i(rst_n), .pipe_if(bn),
        .stall_cnt_o(n_stall_cnt), .flush_cnt_o(n_flush_cnt)
    );
    if_id_pipe_stage #(.CNT_W(4)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .pipe_if(bs),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] npc;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    logic [31:0] s_insn [4] = '{32'h00500093, 32'h00a00113, 32'h00f00193, 32'h01400213};

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv_m(input logic v, input logic h, input logic [31:0] insn,
                         input logic [31:0] pc, input logic st, input logic fl);
        bm.in_valid     = v;
        bm.hit          = h;
        bm.instruction  = insn;
        bm.pc           = pc;
        bm.pc_plus_four = pc + 32'd4;
        bm.stall        = st;
        bm.flush        = fl;
    endtask

    task automatic idle_m();
        drv_m(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] insn, input logic [31:0] pc);
        exp_q.push_back('{insn: insn, pc: pc, npc: pc + 32'd4});
    endtask

    // Monitor: every beat leaving the main DUT must match the queue head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (!bm.out_valid) begin
                chk("nop_when_invalid", 96'(bm.out_instruction), 96'(NOP));
            end else if (!bm.stall && !bm.flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got beat insn=%0h pc=%0h, expected no beat",
                             bm.out_instruction, bm.out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_beat", {bm.out_instruction, bm.out_pc, bm.out_next_pc}, 96'(mon_e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_m();
        bn.in_valid = 1'b0; bn.hit = 1'b0; bn.instruction = '0; bn.pc = '0;
        bn.pc_plus_four = '0; bn.stall = 1'b0; bn.flush = 1'b0;
        bs.in_valid = 1'b0; bs.hit = 1'b0; bs.instruction = '0; bs.pc = '0;
        bs.pc_plus_four = '0; bs.stall = 1'b0; bs.flush = 1'b0;

        // Reset state
        repeat (3) nxt();
        chk("rst_out_valid", 96'(bm.out_valid), 96'(0));
        chk("rst_out_insn",  96'(bm.out_instruction), 96'(NOP));
        chk("rst_out_pc",    96'(bm.out_pc), 96'(0));
        chk("rst_out_npc",   96'(bm.out_next_pc), 96'(0));
        chk("rst_in_ready",  96'(bm.in_ready), 96'(0));
        chk("rst_stall_cnt", 96'(m_stall_cnt), 96'(0));
        chk("rst_flush_cnt", 96'(m_flush_cnt), 96'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Streaming, one beat per cycle
        for (int k = 0; k < 4; k++) begin
            drv_m(1'b1, 1'b1, s_insn[k], 32'h100 + 32'(4 * k), 1'b0, 1'b0);
            push(s_insn[k], 32'h100 + 32'(4 * k));
            smp();
            chk("stream_in_ready", 96'(bm.in_ready), 96'(1));
            if (k == 1) begin
                chk("first_out_valid", 96'(bm.out_valid), 96'(1));
                chk("first_out_pc",    96'(bm.out_pc), 96'(32'h100));
                chk("first_out_npc",   96'(bm.out_next_pc), 96'(32'h104));
            end
            nxt();
        end
        idle_m();
        repeat (2) nxt();

        // Stall with skid: A in main, B in skid, C refused until drain
        drv_m(1'b1, 1'b1, 32'h0aa00093, 32'h200, 1'b0, 1'b0); push(32'h0aa00093, 32'h200); nxt();
        drv_m(1'b1, 1'b1, 32'h0bb00113, 32'h204, 1'b1, 1'b0); push(32'h0bb00113, 32'h204);
        smp(); chk("skid_b_ready", 96'(bm.in_ready), 96'(1)); nxt();
        drv_m(1'b1, 1'b1, 32'h0cc00193, 32'h208, 1'b1, 1'b0);
        smp(); chk("skid_full_ready", 96'(bm.in_ready), 96'(0)); nxt();
        smp(); chk("skid_full_ready2", 96'(bm.in_ready), 96'(0)); nxt();
        bm.stall = 1'b0;
        smp();
        chk("stall_cnt_3",     96'(m_stall_cnt), 96'(3));
        chk("drain_ready_low", 96'(bm.in_ready), 96'(0));
        chk("held_a_pc",       96'(bm.out_pc), 96'(32'h200));
        nxt();
        push(32'h0cc00193, 32'h208);
        smp(); chk("drain_ready_high", 96'(bm.in_ready), 96'(1)); nxt();
        idle_m();
        repeat (2) nxt();

        // Flush with main and skid full, combined with stall
        drv_m(1'b1, 1'b1, 32'h0dd00093, 32'h300, 1'b0, 1'b0); nxt();
        drv_m(1'b1, 1'b1, 32'h0ee00113, 32'h304, 1'b1, 1'b0); nxt();
        drv_m(1'b1, 1'b1, 32'h0ff00193, 32'h308, 1'b1, 1'b1);
        smp(); chk("pre_flush_valid", 96'(bm.out_valid), 96'(1)); nxt();
        idle_m();
        smp();
        chk("flush_out_valid", 96'(bm.out_valid), 96'(0));
        chk("flush_out_insn",  96'(bm.out_instruction), 96'(NOP));
        chk("flush_pc_hold",   96'(bm.out_pc), 96'(32'h300));
        chk("flush_npc_hold",  96'(bm.out_next_pc), 96'(32'h304));
        chk("flush_cnt_1",     96'(m_flush_cnt), 96'(1));
        chk("flush_no_stall",  96'(m_stall_cnt), 96'(4));
        chk("flush_skid_empty", 96'(bm.in_ready), 96'(1));
        nxt();
        smp(); chk("flush_d_dropped", 96'(bm.out_valid), 96'(0)); nxt();
        drv_m(1'b1, 1'b1, 32'h11100093, 32'h30c, 1'b0, 1'b1); nxt();
        idle_m();
        smp();
        chk("flush_in_fire_dropped", 96'(bm.out_valid), 96'(0));
        chk("flush_empty_cnt",       96'(m_flush_cnt), 96'(1));
        nxt();

        // Cache miss for 4 cycles, hit on the 5th
        drv_m(1'b1, 1'b0, 32'h22200093, 32'h400, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("miss_no_valid", 96'(bm.out_valid), 96'(0));
            nxt();
        end
        bm.hit = 1'b1;
        push(32'h22200093, 32'h400);
        smp(); chk("miss_still_empty", 96'(bm.out_valid), 96'(0)); nxt();
        idle_m();
        smp(); chk("hit_out_valid", 96'(bm.out_valid), 96'(1)); nxt();

        // Async reset while main and skid are full
        drv_m(1'b1, 1'b1, 32'h33300093, 32'h500, 1'b0, 1'b0); nxt();
        drv_m(1'b1, 1'b1, 32'h44400113, 32'h504, 1'b1, 1'b0); nxt();
        idle_m();
        bm.stall = 1'b1;
        #3;
        chk("pre_rst_valid",     96'(bm.out_valid), 96'(1));
        chk("pre_rst_skid_full", 96'(bm.in_ready), 96'(0));
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 96'(bm.out_valid), 96'(0));
        chk("arst_out_insn",  96'(bm.out_instruction), 96'(NOP));
        chk("arst_out_pc",    96'(bm.out_pc), 96'(0));
        chk("arst_out_npc",   96'(bm.out_next_pc), 96'(0));
        chk("arst_in_ready",  96'(bm.in_ready), 96'(0));
        chk("arst_stall_cnt", 96'(m_stall_cnt), 96'(0));
        chk("arst_flush_cnt", 96'(m_flush_cnt), 96'(0));
        nxt();
        idle_m();
        rst_n = 1'b1;
        drv_m(1'b1, 1'b1, 32'h55500093, 32'h600, 1'b0, 1'b0); push(32'h55500093, 32'h600);
        nxt();
        idle_m();
        smp(); chk("post_rst_valid", 96'(bm.out_valid), 96'(1)); nxt();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) nxt();
        chk("sb_drained", 96'(exp_q.size()), 96'(0));

        // SKID_EN=0: combinational ready
        bn.in_valid = 1'b1; bn.hit = 1'b1; bn.instruction = 32'h66600093;
        bn.pc = 32'h700; bn.pc_plus_four = 32'h704; bn.stall = 1'b0;
        smp(); chk("nsk_ready_empty", 96'(bn.in_ready), 96'(1)); nxt();
        bn.instruction = 32'h77700113; bn.pc = 32'h704; bn.pc_plus_four = 32'h708; bn.stall = 1'b1;
        smp();
        chk("nsk_ready_stall", 96'(bn.in_ready), 96'(0));
        chk("nsk_out_n1",      96'(bn.out_instruction), 96'(32'h66600093));
        bn.stall = 1'b0;
        #1;
        chk("nsk_ready_free", 96'(bn.in_ready), 96'(1));
        nxt();
        bn.in_valid = 1'b0; bn.hit = 1'b0;
        smp();
        chk("nsk_out_n2",    96'(bn.out_instruction), 96'(32'h77700113));
        chk("nsk_out_n2_pc", 96'(bn.out_pc), 96'(32'h704));
        nxt();
        smp();
        chk("nsk_empty_valid", 96'(bn.out_valid), 96'(0));
        chk("nsk_empty_nop",   96'(bn.out_instruction), 96'(NOP));
        nxt();

        // CNT_W=4: stall counter saturates at 15
        bs.in_valid = 1'b1; bs.hit = 1'b1; bs.instruction = 32'h88800093;
        bs.pc = 32'h800; bs.pc_plus_four = 32'h804;
        nxt();
        bs.in_valid = 1'b0; bs.hit = 1'b0; bs.stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            nxt();
            if (i == 10) chk("sat_cnt_10", 96'(s_stall_cnt), 96'(10));
        end
        chk("sat_cnt_15", 96'(s_stall_cnt), 96'(15));
        nxt();
        chk("sat_cnt_hold", 96'(s_stall_cnt), 96'(15));
        bs.stall = 1'b0;
        nxt();
        chk("sat_cnt_after", 96'(s_stall_cnt), 96'(15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
